// File: rtl/fetch_dec_queue_if.sv
// Fetch-to-decode bundle bus: four 16-bit slots per bundle plus flush, stall and error status.
// master = fetch/decode/ROB side, slave = the queue.
interface fetch_dec_queue_if;
    logic        has_mispredict;
    logic [3:0]  valid_from_fetch;
    logic [63:0] pc_from_fetch;
    logic [63:0] inst_from_fetch;
    logic [63:0] recv_pc_from_fetch;
    logic [3:0]  pred_from_fetch;
    logic        dec_rdy;
    logic [3:0]  valid_to_dec;
    logic [63:0] pc_to_dec;
    logic [63:0] inst_to_dec;
    logic [63:0] recv_pc_to_dec;
    logic [3:0]  pred_result_to_dec;
    logic        stall_fetch;
    logic        overflow_err;

    modport master (
        output has_mispredict, valid_from_fetch, pc_from_fetch, inst_from_fetch,
               recv_pc_from_fetch, pred_from_fetch, dec_rdy,
        input  valid_to_dec, pc_to_dec, inst_to_dec, recv_pc_to_dec,
               pred_result_to_dec, stall_fetch, overflow_err
    );

    modport slave (
        input  has_mispredict, valid_from_fetch, pc_from_fetch, inst_from_fetch,
               recv_pc_from_fetch, pred_from_fetch, dec_rdy,
        output valid_to_dec, pc_to_dec, inst_to_dec, recv_pc_to_dec,
               pred_result_to_dec, stall_fetch, overflow_err
    );
endinterface

// File: rtl/fetch_dec_queue.sv
// Bundle-granular fetch->decode queue with mispredict flush; optional FDQ_BYPASS_EN empty-queue bypass.
// Latency: head is fall-through, 1 cycle push-to-visible (0 cycles with FDQ_BYPASS_EN when empty).
// Backpressure: stall_fetch from registered count at DEPTH-AFULL_MARGIN; pushes while full are dropped and flagged.
module fetch_dec_queue #(
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_dec_queue_if.slave   q_if
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_LVL = (AW+1)'(DEPTH - AFULL_MARGIN);

    typedef struct packed {
        logic [3:0]  vld;
        logic [63:0] pc;
        logic [63:0] inst;
        logic [63:0] recv_pc;
        logic [3:0]  pred;
    } bundle_t;

    bundle_t        mem [DEPTH];
    logic [AW-1:0]  head;
    logic [AW-1:0]  tail;
    logic [AW:0]    count;
    logic           overflow_q;

    bundle_t        in_b;
    bundle_t        out_b;
    logic           flush;
    logic           push_req;
    logic           pop;
    logic           byp_take;
    logic           push_ok;
    logic           push_drop;

    assign in_b = '{vld: q_if.valid_from_fetch, pc: q_if.pc_from_fetch,
                    inst: q_if.inst_from_fetch, recv_pc: q_if.recv_pc_from_fetch,
                    pred: q_if.pred_from_fetch};

    assign flush    = q_if.has_mispredict;
    assign push_req = |q_if.valid_from_fetch;
    assign pop      = q_if.dec_rdy && (count != '0) && !flush;

`ifdef FDQ_BYPASS_EN
    // Empty queue: decode takes the incoming bundle directly, nothing is written.
    assign byp_take = (count == '0) && !flush && push_req && q_if.dec_rdy;
`else
    assign byp_take = 1'b0;
`endif

    assign push_ok   = push_req && !flush && !byp_take && ((count < FULL_LVL) || pop);
    assign push_drop = push_req && !flush && (count == FULL_LVL) && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_drop)
                overflow_q <= 1'b1;
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (pop)
                    head <= head + AW'(1);
                if (push_ok)
                    tail <= tail + AW'(1);
                if (push_ok && !pop)
                    count <= count + (AW+1)'(1);
                else if (pop && !push_ok)
                    count <= count - (AW+1)'(1);
            end
        end
    end

    // Payload storage carries no reset; outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[tail] <= in_b;
    end

    always_comb begin
        out_b = '0;
        if (!flush) begin
            if (count != '0)
                out_b = mem[head];
`ifdef FDQ_BYPASS_EN
            else if (push_req)
                out_b = in_b;
`endif
        end
    end

    assign q_if.valid_to_dec       = out_b.vld;
    assign q_if.pc_to_dec          = out_b.pc;
    assign q_if.inst_to_dec        = out_b.inst;
    assign q_if.recv_pc_to_dec     = out_b.recv_pc;
    assign q_if.pred_result_to_dec = out_b.pred;
    assign q_if.stall_fetch        = (count >= AFULL_LVL);
    assign q_if.overflow_err       = overflow_q;
endmodule
